cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_parser.sv | 222 ++++++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser.sv
// Command frame parser: turns a byte stream of opcode+operand frames into held register-file/ALU commands.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
//
//   state       | meaning
//   S_IDLE      | waiting for an opcode byte
//   S_GET_ADDR  | waiting for the register address (write or read)
//   S_GET_WDATA | waiting for the write data
//   S_GET_A     | waiting for ALU operand A
//   S_GET_B     | waiting for ALU operand B
//   S_GET_FUN   | waiting for the ALU function code
//   S_HOLD      | command presented on CMD_*, waiting for CMD_RDY
module cmd_frame_parser #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  CMD_RDY,
    output logic                  CMD_VLD,
    output logic [1:0]            CMD_TYPE,
    output logic [ADDR_WIDTH-1:0] CMD_ADDR,
    output logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic [DATA_WIDTH-1:0] CMD_OPB,
    output logic [3:0]            CMD_FUN,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_WDATA,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_HOLD
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALUN = DATA_WIDTH'(8'hDD);

    localparam logic [1:0] TYPE_WR   = 2'b00;
    localparam logic [1:0] TYPE_RD   = 2'b01;
    localparam logic [1:0] TYPE_ALU  = 2'b10;
    localparam logic [1:0] TYPE_ALUN = 2'b11;

    if (DATA_WIDTH < 8 || ADDR_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cmd_frame_parser: unsupported parameter combination");
    end

    state_t                  state_q, state_d;
    logic                    vld_q, vld_d;
    logic [1:0]              type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]              fun_q, fun_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    in_get;
`endif

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        opb_d   = opb_q;
        fun_d   = fun_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    // Clearing at frame start leaves unloaded fields at zero on completion.
                    addr_d  = '0;
                    wdata_d = '0;
                    opb_d   = '0;
                    fun_d   = '0;
                    if (RX_P_DATA == OP_WR) begin
                        type_d  = TYPE_WR;
                        state_d = S_GET_ADDR;
                    end else if (RX_P_DATA == OP_RD) begin
                        type_d  = TYPE_RD;
                        state_d = S_GET_ADDR;
                    end else if (RX_P_DATA == OP_ALU) begin
                        type_d  = TYPE_ALU;
                        state_d = S_GET_A;
                    end else if (RX_P_DATA == OP_ALUN) begin
                        type_d  = TYPE_ALUN;
                        state_d = S_GET_FUN;
                    end else begin
                        addr_d  = addr_q;
                        wdata_d = wdata_q;
                        opb_d   = opb_q;
                        fun_d   = fun_q;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    if (type_q == TYPE_WR) begin
                        state_d = S_GET_WDATA;
                    end else begin
                        state_d = S_HOLD;
                        vld_d   = 1'b1;
                    end
                end
            end
            S_GET_WDATA: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    state_d = S_HOLD;
                    vld_d   = 1'b1;
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    opb_d   = RX_P_DATA;
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[3:0];
                    state_d = S_HOLD;
                    vld_d   = 1'b1;
                end
            end
            S_HOLD: begin
                // A byte here is lost even if the command is released this same cycle.
                if (RX_D_VLD) begin
                    ovr_d = 1'b1;
                end
                if (CMD_RDY) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase

`ifdef CMD_TIMEOUT_EN
        in_get = (state_q != S_IDLE) && (state_q != S_HOLD);
        cnt_d  = '0;
        if (in_get && !RX_D_VLD) begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
                ferr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`else
        // Without the timeout a partial frame waits for its next byte indefinitely.
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            opb_q   <= '0;
            fun_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            opb_q   <= opb_d;
            fun_q   <= fun_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef CMD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign CMD_VLD   = vld_q;
    assign CMD_TYPE  = type_q;
    assign CMD_ADDR  = addr_q;
    assign CMD_WDATA = wdata_q;
    assign CMD_OPB   = opb_q;
    assign CMD_FUN   = fun_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed self-checking bench for cmd_frame_parser; inputs driven and outputs sampled on the falling edge.
module tb_cmd_frame_parser;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       CMD_RDY;
    logic       CMD_VLD;
    logic [1:0] CMD_TYPE;
    logic [3:0] CMD_ADDR;
    logic [7:0] CMD_WDATA;
    logic [7:0] CMD_OPB;
    logic [3:0] CMD_FUN;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int checks = 0;
    int errs   = 0;

    always #5 CLK = ~CLK;

    cmd_frame_parser #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_P_DATA(RX_P_DATA),
        .RX_D_VLD(RX_D_VLD),
        .CMD_RDY(CMD_RDY),
        .CMD_VLD(CMD_VLD),
        .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR),
        .CMD_WDATA(CMD_WDATA),
        .CMD_OPB(CMD_OPB),
        .CMD_FUN(CMD_FUN),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN(OVERRUN)
    );

    // One-cycle RX_D_VLD pulse; returns on the falling edge after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic check_fields(input string nm, input logic v, input logic [1:0] t,
                                input logic [3:0] a, input logic [7:0] w,
                                input logic [7:0] o, input logic [3:0] f);
        checks++;
        if ({CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPB, CMD_FUN} !== {v, t, a, w, o, f}) begin
            errs++;
            $display("FAIL %s: got vld=%0b type=%0d addr=%h wdata=%h opb=%h fun=%h, expected vld=%0b type=%0d addr=%h wdata=%h opb=%h fun=%h",
                     nm, CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPB, CMD_FUN, v, t, a, w, o, f);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; CMD_RDY = 1'b0;
        #2;
        check_fields("reset_fields", 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 4'h0);
        checks++;
        if ({FRAME_ERR, OVERRUN} !== 2'b00) begin
            errs++; $display("FAIL reset_pulses: got ferr=%0b ovr=%0b, expected 0 0", FRAME_ERR, OVERRUN);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_write;
        CMD_RDY = 1'b1;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check_fields("write_cmd", 1'b1, 2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
        @(negedge CLK);
        checks++;
        if (CMD_VLD !== 1'b0) begin
            errs++; $display("FAIL write_vld_fall: got %0b, expected 0", CMD_VLD);
        end
    endtask

    task automatic test_alu_hold;
        int ovr_cnt = 0;
        CMD_RDY = 1'b0;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'hF1);
        for (int i = 0; i < 5; i++) begin
            check_fields("alu_hold", 1'b1, 2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
            if (i == 1) begin
                RX_P_DATA = 8'h77; RX_D_VLD = 1'b1;
            end
            @(negedge CLK);
            RX_D_VLD = 1'b0;
            if (OVERRUN === 1'b1) ovr_cnt++;
        end
        checks++;
        if (ovr_cnt != 1) begin
            errs++; $display("FAIL alu_overrun_count: got %0d pulses, expected 1", ovr_cnt);
        end
        check_fields("alu_after_overrun", 1'b1, 2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
        CMD_RDY = 1'b1;
        @(negedge CLK);
        checks++;
        if (CMD_VLD !== 1'b0) begin
            errs++; $display("FAIL alu_release: got vld=%0b, expected 0", CMD_VLD);
        end
    endtask

    task automatic test_overrun_with_rdy;
        CMD_RDY = 1'b0;
        send_byte(8'hBB); send_byte(8'h03);
        check_fields("rd_hold", 1'b1, 2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        RX_P_DATA = 8'hDD; RX_D_VLD = 1'b1; CMD_RDY = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        checks++;
        if ({OVERRUN, CMD_VLD, FRAME_ERR} !== 3'b100) begin
            errs++; $display("FAIL overrun_rdy: got ovr=%0b vld=%0b ferr=%0b, expected 1 0 0", OVERRUN, CMD_VLD, FRAME_ERR);
        end
        send_byte(8'hBB); send_byte(8'h09);
        check_fields("after_dropped_opcode", 1'b1, 2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
        @(negedge CLK);
    endtask

    task automatic test_illegal_opcode;
        CMD_RDY = 1'b1;
        send_byte(8'h5A);
        checks++;
        if ({FRAME_ERR, CMD_VLD} !== 2'b10) begin
            errs++; $display("FAIL illegal_ferr: got ferr=%0b vld=%0b, expected 1 0", FRAME_ERR, CMD_VLD);
        end
        @(negedge CLK);
        checks++;
        if (FRAME_ERR !== 1'b0) begin
            errs++; $display("FAIL illegal_ferr_pulse: got %0b on second cycle, expected 0", FRAME_ERR);
        end
        send_byte(8'hDD); send_byte(8'h03);
        check_fields("alun_cmd", 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 4'h3);
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_frame;
        CMD_RDY = 1'b0;
        send_byte(8'hAA); send_byte(8'h02);
        RST = 1'b0;
        #1;
        check_fields("mid_reset_fields", 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 4'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        send_byte(8'hBB); send_byte(8'h07);
        check_fields("post_reset_read", 1'b1, 2'd1, 4'h7, 8'h00, 8'h00, 4'h0);
        CMD_RDY = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_opcode_as_data;
        CMD_RDY = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hAA);
        check_fields("opcode_as_wdata", 1'b1, 2'd0, 4'h1, 8'hAA, 8'h00, 4'h0);
        @(negedge CLK);
        send_byte(8'hBB); send_byte(8'h3F);
        check_fields("addr_upper_ignored", 1'b1, 2'd1, 4'hF, 8'h00, 8'h00, 4'h0);
        checks++;
        if (FRAME_ERR !== 1'b0) begin
            errs++; $display("FAIL addr_upper_ferr: got %0b, expected 0", FRAME_ERR);
        end
        @(negedge CLK);
        send_byte(8'hDD); send_byte(8'hF7);
        check_fields("fun_upper_ignored", 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
        @(negedge CLK);
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout;
        int early = 0;
        CMD_RDY = 1'b1;
        send_byte(8'hCC);
        for (int i = 1; i < 16; i++) begin
            @(negedge CLK);
            if (FRAME_ERR === 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errs++; $display("FAIL timeout_early: got %0d early pulses, expected 0", early);
        end
        @(negedge CLK);
        checks++;
        if ({FRAME_ERR, CMD_VLD} !== 2'b10) begin
            errs++; $display("FAIL timeout_ferr: got ferr=%0b vld=%0b, expected 1 0", FRAME_ERR, CMD_VLD);
        end
        send_byte(8'h12);
        checks++;
        if (FRAME_ERR !== 1'b1) begin
            errs++; $display("FAIL timeout_then_illegal: got ferr=%0b, expected 1", FRAME_ERR);
        end
        @(negedge CLK);
    endtask
`else
    task automatic test_no_timeout;
        int ferr_seen = 0;
        CMD_RDY = 1'b1;
        send_byte(8'hCC);
        repeat (40) begin
            @(negedge CLK);
            if (FRAME_ERR === 1'b1 || CMD_VLD === 1'b1) ferr_seen++;
        end
        checks++;
        if (ferr_seen != 0) begin
            errs++; $display("FAIL no_timeout_idle: got %0d active cycles, expected 0", ferr_seen);
        end
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hF1);
        check_fields("no_timeout_alu", 1'b1, 2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
        @(negedge CLK);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_alu_hold();
        test_overrun_with_rdy();
        test_illegal_opcode();
        test_reset_mid_frame();
        test_opcode_as_data();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
